// File: rtl/swap_remap_ctrl.sv
// Purpose: arbitrates remap requests, fences and drains the two affected ports, then strobes the port-swap unit.
// Latency: accept at T with both ports idle -> select_o at T+2, done_o at T+3; errors report at T+1.
// Backpressure: req_ready_o is only offered in IDLE; requesters hold valid/payload until their ready is seen.
module swap_remap_ctrl #(
    parameter int N_INIT_PORT = 8,
    parameter int LOG_N_INIT  = 3,
    parameter int N_REQ       = 2,
    parameter int OUTST_W     = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*LOG_N_INIT-1:0] req_source_i,
    input  logic [N_REQ*LOG_N_INIT-1:0] req_target_i,
    input  logic [N_INIT_PORT-1:0]      aw_issue_i,
    input  logic [N_INIT_PORT-1:0]      b_done_i,
    output logic [N_INIT_PORT-1:0]      hold_o,
    output logic                        select_o,
    output logic [LOG_N_INIT-1:0]       source_o,
    output logic [LOG_N_INIT-1:0]       target_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [1:0]                  err_code_o
);

    localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [RR_W-1:0]       rr_ptr_q;
    logic [RR_W-1:0]       winner;
    logic                  any_vld;
    logic                  accept;
    logic [LOG_N_INIT-1:0] win_src, win_tgt;
    logic [LOG_N_INIT-1:0] src_q, tgt_q;
    logic [1:0]            chk_code;
    logic [1:0]            code_q;
    logic [TMO_W-1:0]      tmo_cnt_q;
    logic                  tmo_hit;
    logic [OUTST_W-1:0]    outst_q [N_INIT_PORT];
    logic [N_INIT_PORT-1:0] port_sel;
    logic                  drained;

    // Requester index base+off, wrapped into 0..N_REQ-1.
    function automatic logic [RR_W-1:0] rr_add(input logic [RR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return RR_W'(s);
    endfunction

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        winner  = rr_ptr_q;
        any_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[rr_add(rr_ptr_q, i)]) begin
                winner  = rr_add(rr_ptr_q, i);
                any_vld = 1'b1;
            end
        end
    end

    assign accept  = (state_q == IDLE) && any_vld;
    assign win_src = req_source_i[int'(winner)*LOG_N_INIT +: LOG_N_INIT];
    assign win_tgt = req_target_i[int'(winner)*LOG_N_INIT +: LOG_N_INIT];

    // Ready goes only to the winner, and only while IDLE.
    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[winner] = 1'b1;
    end

    // Request validation; an out-of-range index outranks source==target.
    always_comb begin
        chk_code = 2'd0;
        if (int'(win_src) >= N_INIT_PORT || int'(win_tgt) >= N_INIT_PORT) chk_code = 2'd2;
        else if (win_src == win_tgt)                                   chk_code = 2'd1;
    end

    // Ports touched by the latched remap and whether both have drained.
    always_comb begin
        drained = 1'b1;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            port_sel[i] = (src_q == LOG_N_INIT'(i)) || (tgt_q == LOG_N_INIT'(i));
            if (port_sel[i] && (outst_q[i] != '0)) drained = 1'b0;
        end
    end

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT));

    // Per-port outstanding-write counters; they run in every state so in-flight AWs are never lost.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_INIT_PORT; i++) begin
            if (rst)
                outst_q[i] <= '0;
            else if (aw_issue_i[i] && !b_done_i[i] && (outst_q[i] != '1))
                outst_q[i] <= outst_q[i] + 1'b1;
            else if (!aw_issue_i[i] && b_done_i[i] && (outst_q[i] != '0))
                outst_q[i] <= outst_q[i] - 1'b1;
        end
    end

    // State register plus latched request, result code, rr pointer and drain timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            src_q     <= '0;
            tgt_q     <= '0;
            code_q    <= 2'd0;
            tmo_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rr_ptr_q <= rr_add(winner, 1);
                src_q    <= win_src;
                tgt_q    <= win_tgt;
                code_q   <= chk_code;
            end else if (state_q == DRAIN && !drained && tmo_hit) begin
                code_q <= 2'd3;
            end
            tmo_cnt_q <= (state_q == DRAIN) ? tmo_cnt_q + 1'b1 : '0;
        end
    end

    assign source_o = src_q;
    assign target_o = tgt_q;
    assign busy_o   = (state_q != IDLE);

    // Next state and strobes; everything defaults low so IDLE and reset present all zeros.
    always_comb begin
        state_d    = state_q;
        hold_o     = '0;
        select_o   = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        err_code_o = 2'd0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (chk_code != 2'd0) ? RESP : DRAIN;
            end
            DRAIN: begin
                hold_o = port_sel;
                if (drained)      state_d = COMMIT;
                else if (tmo_hit) state_d = RESP;
            end
            COMMIT: begin
                hold_o   = port_sel;
                select_o = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (code_q == 2'd0) begin
                    done_o = 1'b1;
                end else begin
                    err_o      = 1'b1;
                    err_code_o = code_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_swap_remap_ctrl.sv
// Purpose: scoreboard bench for swap_remap_ctrl with six initiator ports so out-of-range indices are reachable.
// Latency: expectations carry the exact cycle each select/done/err strobe must appear.
// Backpressure: requests are held until ready; ready timing is checked directly by the stimulus.
module tb_swap_remap_ctrl;

    localparam int NP  = 6;
    localparam int LG  = 3;
    localparam int NR  = 2;
    localparam int OW  = 4;
    localparam int TMO = 255;

    localparam int K_SEL  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid_i;
    logic [NR-1:0]    req_ready_o;
    logic [NR*LG-1:0] req_source_i;
    logic [NR*LG-1:0] req_target_i;
    logic [NP-1:0]    aw_issue_i;
    logic [NP-1:0]    b_done_i;
    logic [NP-1:0]    hold_o;
    logic             select_o;
    logic [LG-1:0]    source_o;
    logic [LG-1:0]    target_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [1:0]       err_code_o;

    swap_remap_ctrl #(
        .N_INIT_PORT(NP), .LOG_N_INIT(LG), .N_REQ(NR), .OUTST_W(OW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_source_i(req_source_i), .req_target_i(req_target_i),
        .aw_issue_i(aw_issue_i), .b_done_i(b_done_i),
        .hold_o(hold_o), .select_o(select_o),
        .source_o(source_o), .target_o(target_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t sb_q[$];
    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_pass = 0;
    int  exp_rr = 0;
    int  t_acc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push(input int k, input int c, input int a, input int b);
        ev_t e;
        e = '{k, c, a, b};
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int k, input int a, input int b);
        ev_t e;
        n_chk++;
        if (sb_q.size() == 0) begin
            $display("FAIL sb_unexpected: kind=%0d a=%0d b=%0d at cycle %0d, nothing expected", k, a, b, cyc);
        end else begin
            e = sb_q.pop_front();
            if (e.kind == k && e.cyc == cyc && e.a == a && e.b == b) n_pass++;
            else $display("FAIL sb_event: got kind=%0d cyc=%0d a=%0d b=%0d, expected kind=%0d cyc=%0d a=%0d b=%0d",
                          k, cyc, a, b, e.kind, e.cyc, e.a, e.b);
        end
    endtask

    // Monitor: every strobe the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        if (select_o) sb_pop(K_SEL, int'(source_o), int'(target_o));
        if (done_o)   sb_pop(K_DONE, 0, 0);
        if (err_o)    sb_pop(K_ERR, int'(err_code_o), 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a single request, check it is accepted immediately, queue its expected outcome.
    // mode: 0 = success with idle ports, 1/2 = immediate error code, 9 = caller queues the outcome.
    task automatic issue(input int r, input int s, input int t, input int mode);
        req_valid_i[r] = 1'b1;
        req_source_i[r*LG +: LG] = LG'(s);
        req_target_i[r*LG +: LG] = LG'(t);
        #1;
        chk($sformatf("ready_req%0d", r), int'(req_ready_o), 1 << r);
        t_acc  = cyc;
        exp_rr = (r + 1) % NR;
        if (mode == 0) begin
            push(K_SEL, t_acc + 2, s, t);
            push(K_DONE, t_acc + 3, 0, 0);
        end else if (mode == 1 || mode == 2) begin
            push(K_ERR, t_acc + 1, mode, 0);
        end
        tick();
        req_valid_i[r] = 1'b0;
    endtask

    initial begin
        int c;
        int w;
        rst          = 1'b1;
        req_valid_i  = '0;
        req_source_i = '0;
        req_target_i = '0;
        aw_issue_i   = '0;
        b_done_i     = '0;
        repeat (3) tick();
        chk("rst_hold", int'(hold_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ready", int'(req_ready_o), 0);
        chk("rst_src_tgt", int'({source_o, target_o}), 0);
        chk("rst_strobes", int'({select_o, done_o, err_o, err_code_o}), 0);
        rst = 1'b0;
        tick();

        // Basic remap 1->2 with idle ports.
        issue(0, 1, 2, 0);
        chk("basic_hold_t1", int'(hold_o), 'h06);
        chk("basic_busy_t1", int'(busy_o), 1);
        tick();
        chk("basic_hold_t2", int'(hold_o), 'h06);
        chk("basic_src_t2", int'(source_o), 1);
        chk("basic_tgt_t2", int'(target_o), 2);
        tick();
        chk("basic_hold_t3", int'(hold_o), 0);
        tick();
        chk("basic_busy_t4", int'(busy_o), 0);

        // Drain wait: three writes outstanding on port 1, then four responses (one cancelled by a new AW).
        aw_issue_i[1] = 1'b1;
        repeat (3) tick();
        aw_issue_i[1] = 1'b0;
        issue(0, 1, 2, 9);
        repeat (3) tick();
        chk("drain_hold_wait", int'(hold_o), 'h06);
        chk("drain_busy_wait", int'(busy_o), 1);
        b_done_i[1] = 1'b1;
        tick();
        aw_issue_i[1] = 1'b1;
        tick();
        aw_issue_i[1] = 1'b0;
        tick();
        c = cyc;
        push(K_SEL, c + 2, 1, 2);
        push(K_DONE, c + 3, 0, 0);
        tick();
        b_done_i[1] = 1'b0;
        repeat (4) tick();

        // Round-robin with both requesters held continuously.
        req_source_i = {LG'(3), LG'(1)};
        req_target_i = {LG'(4), LG'(2)};
        req_valid_i  = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            w = exp_rr;
            chk($sformatf("rr_ready_%0d", k), int'(req_ready_o), 1 << w);
            push(K_SEL, cyc + 2, (w == 0) ? 1 : 3, (w == 0) ? 2 : 4);
            push(K_DONE, cyc + 3, 0, 0);
            exp_rr = (w + 1) % NR;
            tick();
            if (k == 3) req_valid_i = '0;
            chk($sformatf("rr_ready_busy_%0d", k), int'(req_ready_o), 0);
            repeat (3) tick();
        end

        // A single requester held valid is accepted every fourth cycle.
        req_valid_i[1] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("single_ready_%0d", k), int'(req_ready_o), 2);
            push(K_SEL, cyc + 2, 3, 4);
            push(K_DONE, cyc + 3, 0, 0);
            exp_rr = 0;
            tick();
            if (k == 2) req_valid_i = '0;
            repeat (3) tick();
        end

        // Rejections, including the out-of-range boundary and code-2 priority.
        issue(0, 3, 3, 1);
        tick();
        issue(1, 1, 7, 2);
        tick();
        issue(0, 7, 7, 2);
        tick();
        issue(1, 6, 2, 2);
        tick();
        issue(0, 5, 0, 0);
        repeat (3) tick();

        // Timeout: one write to port 4 never answered.
        aw_issue_i[4] = 1'b1;
        tick();
        aw_issue_i[4] = 1'b0;
        issue(0, 3, 4, 9);
        push(K_ERR, t_acc + TMO + 2, 3, 0);
        chk("tmo_hold_first", int'(hold_o), 'h18);
        repeat (TMO) tick();
        chk("tmo_hold_last", int'(hold_o), 'h18);
        tick();
        chk("tmo_hold_resp", int'(hold_o), 0);
        chk("tmo_busy_resp", int'(busy_o), 1);
        tick();
        chk("tmo_busy_idle", int'(busy_o), 0);
        b_done_i[4] = 1'b1;
        tick();
        b_done_i[4] = 1'b0;
        tick();

        // Reset while stuck in DRAIN.
        aw_issue_i[2] = 1'b1;
        tick();
        aw_issue_i[2] = 1'b0;
        issue(1, 1, 2, 9);
        tick();
        chk("mid_hold_pre", int'(hold_o), 'h06);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rr = 0;
        chk("mid_hold_post", int'(hold_o), 0);
        chk("mid_busy_post", int'(busy_o), 0);
        repeat (3) tick();
        issue(1, 1, 2, 0);
        repeat (4) tick();

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
